// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and helpers for the multi-cycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SLT  = 4'd4,
      OP_SLTU = 4'd5,
      OP_XOR  = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10,
      OP_DIV  = 4'd11,
      OP_DIVU = 4'd12,
      OP_REM  = 4'd13,
      OP_REMU = 4'd14,
      OP_RSVD = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int unsigned shamt_width(input int unsigned data_width);
      return $clog2(data_width);
   endfunction

   function automatic logic is_iter_op(input op_e op);
      return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// ITER_LATENCY must be >= DATA_WIDTH for the iteration to complete.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ITER_LATENCY = DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  op_e                   i_op,
   input  logic [DATA_WIDTH-1:0] i_src_a,
   input  logic [DATA_WIDTH-1:0] i_src_b,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result_c
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(ITER_LATENCY + 1);

   logic          r_busy, r_fin, r_is_mul, r_want_rem, r_neg_q, r_neg_r;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_acc, r_shf, r_opd;

   logic          w_is_mul, w_signed, w_neg_a, w_neg_b, w_step_mul;
   logic [W-1:0]  w_mag_a, w_mag_b, w_acc, w_shf, w_opd;
   logic [W-1:0]  w_acc_nx, w_shf_nx, w_opd_nx, w_quo, w_rem;
   logic [W:0]    w_trial;

   assign w_is_mul = (i_op == OP_MUL);
   assign w_signed = (i_op == OP_DIV) || (i_op == OP_REM);
   assign w_neg_a  = w_signed && i_src_a[W-1];
   assign w_neg_b  = w_signed && i_src_b[W-1];
   assign w_mag_a  = w_neg_a ? -i_src_a : i_src_a;
   assign w_mag_b  = w_neg_b ? -i_src_b : i_src_b;

   // On start the first iteration works on the fresh operands, landing on the accept edge
   always_comb begin
      w_step_mul = i_start ? w_is_mul : r_is_mul;
      w_acc      = i_start ? '0 : r_acc;
      w_shf      = i_start ? (w_is_mul ? i_src_b : w_mag_a) : r_shf;
      w_opd      = i_start ? (w_is_mul ? i_src_a : w_mag_b) : r_opd;
   end

   always_comb begin
      w_trial  = {w_acc, w_shf[W-1]} - {1'b0, w_opd};
      w_acc_nx = w_acc;
      w_shf_nx = w_shf;
      w_opd_nx = w_opd;
      if (w_step_mul) begin
         if (w_shf[0]) w_acc_nx = w_acc + w_opd;
         w_opd_nx = w_opd << 1;
         w_shf_nx = w_shf >> 1;
      end else if (!w_trial[W]) begin
         w_acc_nx = w_trial[W-1:0];
         w_shf_nx = {w_shf[W-2:0], 1'b1};
      end else begin
         w_acc_nx = {w_acc[W-2:0], w_shf[W-1]};
         w_shf_nx = {w_shf[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy     <= 1'b0;
         r_fin      <= 1'b0;
         r_cnt      <= '0;
         r_is_mul   <= 1'b0;
         r_want_rem <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_acc      <= '0;
         r_shf      <= '0;
         r_opd      <= '0;
      end else begin
         r_fin <= 1'b0;
         if (i_start) begin
            r_acc      <= w_acc_nx;
            r_shf      <= w_shf_nx;
            r_opd      <= w_opd_nx;
            r_cnt      <= CW'(1);
            r_busy     <= (ITER_LATENCY > 1);
            r_fin      <= (ITER_LATENCY <= 1);
            r_is_mul   <= w_is_mul;
            r_want_rem <= (i_op == OP_REM) || (i_op == OP_REMU);
            // Divide by zero keeps the all-ones quotient unsigned
            r_neg_q    <= (w_neg_a ^ w_neg_b) && (i_src_b != '0);
            r_neg_r    <= w_neg_a;
         end else if (r_busy) begin
            if (32'(r_cnt) < W) begin
               r_acc <= w_acc_nx;
               r_shf <= w_shf_nx;
               r_opd <= w_opd_nx;
            end
            r_cnt <= r_cnt + CW'(1);
            if (32'(r_cnt) == ITER_LATENCY - 1) begin
               r_busy <= 1'b0;
               r_fin  <= 1'b1;
            end
         end
      end
   end

   assign w_quo      = r_neg_q ? -r_shf : r_shf;
   assign w_rem      = r_neg_r ? -r_acc : r_acc;
   assign o_result_c = r_is_mul ? r_acc : (r_want_rem ? w_rem : w_quo);
   assign o_done     = r_fin;

endmodule

// File: rtl/alu_multicycle.sv
// ALU with valid/ready handshake: single-cycle ops plus iterative MUL/DIV/REM.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned SEL_WIDTH    = 4,
   parameter int unsigned ITER_LATENCY = DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_src_a,
   input  logic [DATA_WIDTH-1:0] i_src_b,
   input  logic [SEL_WIDTH-1:0]  i_sel,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_busy
);

   localparam int unsigned W   = DATA_WIDTH;
   localparam int unsigned SHW = shamt_width(DATA_WIDTH);

   state_e             r_state;
   logic               r_valid, r_busy;
   logic [W-1:0]       r_data;

   logic [SEL_WIDTH+3:0] w_sel_pad;
   op_e                  w_op;
   logic                 w_accept, w_is_iter, w_done;
   logic [SHW-1:0]       w_shamt;
   logic [W-1:0]         w_alu, w_iter_result;

   // Opcodes beyond the 4-bit encoding fall back to ADD
   assign w_sel_pad = {4'b0000, i_sel};
   assign w_op      = (w_sel_pad[SEL_WIDTH+3:4] == '0) ? op_e'(w_sel_pad[3:0]) : OP_ADD;
   assign w_shamt   = i_src_b[SHW-1:0];
   assign w_is_iter = is_iter_op(w_op);
   assign o_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && i_ready);
   assign w_accept  = i_valid && o_ready;

   always_comb begin
      w_alu = i_src_a + i_src_b;
      case (w_op)
         OP_SUB:  w_alu = i_src_a - i_src_b;
         OP_AND:  w_alu = i_src_a & i_src_b;
         OP_OR:   w_alu = i_src_a | i_src_b;
         OP_SLT:  w_alu = W'($signed(i_src_a) < $signed(i_src_b));
         OP_SLTU: w_alu = W'(i_src_a < i_src_b);
         OP_XOR:  w_alu = i_src_a ^ i_src_b;
         OP_SLL:  w_alu = i_src_a << w_shamt;
         OP_SRL:  w_alu = i_src_a >> w_shamt;
         OP_SRA:  w_alu = W'($signed(i_src_a) >>> w_shamt);
         default: ;
      endcase
   end

   alu_muldiv_iter #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ITER_LATENCY (ITER_LATENCY)
   ) u_muldiv (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (w_accept && w_is_iter),
      .i_op       (w_op),
      .i_src_a    (i_src_a),
      .i_src_b    (i_src_b),
      .o_done     (w_done),
      .o_result_c (w_iter_result)
   );

   // A DONE handshake and a new acceptance may share an edge; acceptance wins
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if ((r_state == S_DONE) && i_ready) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end
               if (w_accept) begin
                  if (w_is_iter) begin
                     r_state <= S_BUSY;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_valid <= 1'b1;
                     r_data  <= w_alu;
                  end
               end
            end
            S_BUSY: begin
               if (w_done) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_data  <= w_iter_result;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_valid = r_valid;
   assign o_busy  = r_busy;
   assign o_data  = r_data;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed corner cases plus random traffic.
module tb_alu_multicycle;

   localparam int unsigned W = 32;

   logic         clk, rst, i_valid, i_ready, o_ready, o_valid, o_busy;
   logic [W-1:0] src_a, src_b, o_data;
   logic [3:0]   sel;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   bit          rand_mode = 1'b0;

   alu_multicycle #(
      .DATA_WIDTH   (32),
      .SEL_WIDTH    (4),
      .ITER_LATENCY (32)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_src_a (src_a),
      .i_src_b (src_b),
      .i_sel   (sel),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model straight from the opcode definitions
   function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      logic [4:0]  sh;
      logic [31:0] min_neg;
      sa      = a;
      sb      = b;
      sh      = b[4:0];
      min_neg = 32'h8000_0000;
      case (s)
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd5:  return (a < b) ? 32'd1 : 32'd0;
         4'd6:  return a ^ b;
         4'd7:  return a << sh;
         4'd8:  return a >> sh;
         4'd9:  return 32'(sa >>> sh);
         4'd10: return a * b;
         4'd11: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == min_neg && b == 32'hFFFF_FFFF) return min_neg;
            return 32'(sa / sb);
         end
         4'd12: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         4'd13: begin
            if (b == 32'd0) return a;
            if (a == min_neg && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         4'd14: return (b == 32'd0) ? a : a % b;
         default: return a + b;
      endcase
   endfunction

   // Monitor: every completed output handshake pops one expected result
   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%08h with no pending request at %0t", o_data, $time);
         end else begin
            check("scoreboard", o_data, exp_q.pop_front());
         end
      end
   end

   // Called at posedge+1; holds i_valid and scrambles inputs on cycles the DUT cannot accept
   task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, output int waits);
      waits = 0;
      for (int n = 0; n < 600; n++) begin
         if (rand_mode) i_ready = ($urandom_range(0, 3) != 0);
         #1;
         i_valid = 1'b1;
         if (o_ready) begin
            sel   = s;
            src_a = a;
            src_b = b;
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            sel     = 4'($urandom);
            src_a   = $urandom;
            src_b   = $urandom;
            exp_q.push_back(ref_alu(s, a, b));
            return;
         end
         sel   = 4'($urandom);
         src_a = $urandom;
         src_b = $urandom;
         @(posedge clk);
         #1;
         waits++;
      end
      i_valid = 1'b0;
      check("accept_timeout", 32'(waits), 32'd0);
   endtask

   task automatic measure(output int lat, output int busy_cyc, output int ready_hi, output logic [31:0] d);
      lat      = 1;
      busy_cyc = 0;
      ready_hi = 0;
      d        = 32'hDEAD_BEEF;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (o_valid) begin
            d = o_data;
            break;
         end
         if (o_busy) busy_cyc++;
         if (o_ready) ready_hi++;
         @(posedge clk);
         #1;
         lat++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_dir(input string name, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
      int          w, lat, bc, rh;
      logic [31:0] d;
      issue(s, a, b, w);
      measure(lat, bc, rh, d);
      check({name, "_data"}, d, exp_data);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      if (exp_lat > 1) begin
         check({name, "_busy_cycles"}, 32'(bc), 32'(exp_lat - 1));
         check({name, "_ready_while_busy"}, 32'(rh), 32'd0);
      end
   endtask

   initial begin
      int          w, lat, bc, rh, k;
      logic [31:0] d, a, b;
      logic [3:0]  s;

      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      sel     = 4'd0;
      src_a   = '0;
      src_b   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", 32'(o_valid), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_ready", 32'(o_ready), 32'd1);
      check("reset_data", o_data, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_dir("add_wrap",   4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
      run_dir("sra",        4'd9,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
      run_dir("slt",        4'd4,  32'hFFFF_FFFF, 32'h1,         32'h1,         1);
      run_dir("sltu",       4'd5,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
      run_dir("opcode15",   4'd15, 32'd3,         32'd4,         32'd7,         1);
      run_dir("div_ovf",    4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run_dir("rem_ovf",    4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33);
      run_dir("divu_zero",  4'd12, 32'd7,         32'd0,         32'hFFFF_FFFF, 33);
      run_dir("remu_zero",  4'd14, 32'd7,         32'd0,         32'd7,         33);
      run_dir("div_zero_s", 4'd11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 33);
      run_dir("rem_zero_s", 4'd13, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33);
      run_dir("div_neg",    4'd11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_dir("rem_neg",    4'd13, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_dir("mul_wrap",   4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0,         33);
      run_dir("mul_neg",    4'd10, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33);

      // Consumer stalls in DONE, then releases with a new request waiting
      i_ready = 1'b0;
      issue(4'd0, 32'd10, 32'd20, w);
      measure(lat, bc, rh, d);
      check("hold_first_data", d, 32'd30);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("hold_data", o_data, 32'd30);
         check("hold_ready", 32'(o_ready), 32'd0);
         check("hold_valid", 32'(o_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      i_ready = 1'b1;
      issue(4'd0, 32'd4, 32'd5, w);
      check("b2b_accept_waits", 32'(w), 32'd0);
      measure(lat, bc, rh, d);
      check("b2b_data", d, 32'd9);
      check("b2b_latency", 32'(lat), 32'd1);

      // Reset ten cycles into a divide discards it
      issue(4'd11, 32'h1234_5678, 32'd3, w);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_data", o_data, 32'd0);
      check("midrst_ready", 32'(o_ready), 32'd1);
      check("midrst_busy", 32'(o_busy), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      run_dir("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1);

      // Random traffic with random consumer back-pressure
      rand_mode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         s = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         k = $urandom_range(0, 7);
         if (k == 0) b = 32'd0;
         else if (k == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (k == 2) b = $urandom_range(0, 40);
         issue(s, a, b, w);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               i_ready = ($urandom_range(0, 1) != 0);
               @(posedge clk);
               #1;
            end
         end
      end
      rand_mode = 1'b0;
      i_ready   = 1'b1;
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("drain_pending", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter SEL_WIDTH, default 4, opcode width.
REQ-003 Parameter ITER_LATENCY, default DATA_WIDTH, cycles spent in the iterative multiply/divide datapath.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  request present.
REQ-007 o_ready  output  1  block can accept a request this cycle.
REQ-008 i_src_a, i_src_b  input  DATA_WIDTH  operands.
REQ-009 i_sel  input  SEL_WIDTH  opcode.
REQ-010 o_valid  output  1  o_data holds a result.
REQ-011 i_ready  input  1  consumer accepts result.
REQ-012 o_data  output  DATA_WIDTH  registered result.
REQ-013 o_busy  output  1  iterative operation in progress.

Function
REQ-014 Request accepted on a cycle with i_valid && o_ready; operands and opcode captured at acceptance; inputs ignored otherwise.
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 SLTU, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low half), 11 DIV, 12 DIVU, 13 REM, 14 REMU; 15 and unused codes behave as ADD.
REQ-016 Shift amount = low log2(DATA_WIDTH) bits of i_src_b; SLT/SLTU result zero-extended 0/1; ADD/SUB/MUL wrap modulo 2^DATA_WIDTH.
REQ-017 State machine IDLE, BUSY, DONE; reset enters IDLE.
REQ-018 IDLE: o_ready=1; single-cycle opcode accepted -> DONE next cycle with o_valid=1; opcode 10-14 accepted -> BUSY.
REQ-019 BUSY: o_ready=0, o_busy=1, iteration counter runs ITER_LATENCY cycles then -> DONE; total latency acceptance-to-o_valid = ITER_LATENCY+1 cycles.
REQ-020 DONE: o_valid=1, o_data stable until i_valid-independent handshake o_valid && i_ready; then -> IDLE.
REQ-021 DONE with i_ready=1 SHALL assert o_ready, permitting back-to-back acceptance in the same cycle; next state follows the new opcode per REQ-018.
REQ-022 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = i_src_a; no exception.
REQ-023 Signed overflow (DIV of most-negative by -1): quotient = most-negative, remainder = 0.
REQ-024 Signed DIV/REM: operate on magnitudes, quotient sign = sign(a) xor sign(b), remainder sign = sign(a).
REQ-025 i_valid asserted while o_ready=0 SHALL not disturb in-flight operation.

Reset
REQ-026 Reset at any cycle, including mid-BUSY, returns to IDLE next edge: o_valid=0, o_busy=0, o_ready=1, o_data=0, counter=0; in-flight result discarded.
REQ-027 Reset has priority over every handshake in the same cycle.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode enum (4-bit), the state enum, and helper constant for shift-amount width.
REQ-029 Iterative shift-add multiplier and restoring divider SHALL live in one sub-module alu_muldiv_iter with start/done handshake and sign handling internal.
REQ-030 Single-cycle ops remain combinational feeding the o_data register.

Verification
REQ-031 ADD 0xFFFFFFFF + 1, i_ready=1 -> o_valid one cycle after accept, o_data=0x00000000.
REQ-032 SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 33 cycles; REM same -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-034 MUL 0x00010000 x 0x00010000 -> 0; MUL -3 x 5 -> 0xFFFFFFF1; o_busy high for 32 cycles, o_ready low throughout.
REQ-035 Hold i_ready=0 for 5 cycles in DONE -> o_data stable, o_ready=0; then i_ready=1 with new ADD pending -> accepted same cycle, next result follows one cycle later.
REQ-036 Assert i_rst at cycle 10 of a DIV -> next cycle IDLE, o_valid=0, o_data=0; subsequent ADD 2+3 -> 5.
